// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared encodings for the ULA multicycle control sequencer
package ula_pkg;

    localparam logic [3:0] ULA_AND = 4'b0000;
    localparam logic [3:0] ULA_OR  = 4'b0001;
    localparam logic [3:0] ULA_ADD = 4'b0010;
    localparam logic [3:0] ULA_SUB = 4'b0110;
    localparam logic [3:0] ULA_SLT = 4'b0111;
    localparam logic [3:0] ULA_LUI = 4'b1011;
    localparam logic [3:0] ULA_NOR = 4'b1100;
    localparam logic [3:0] ULA_XOR = 4'b1101;
    localparam logic [3:0] ULA_SLL = 4'b1110;
    localparam logic [3:0] ULA_SRL = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ULA    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/ula_decoder.sv
// rtl/ula_decoder.sv - opcode/funct to ULA operation and instruction class map
module ula_decoder
    import ula_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output logic [3:0]   ula_op,
    output logic         zero_ext,
    output instr_class_t instr_class,
    output logic         is_load,
    output logic         is_bne
);

    always_comb begin
        ula_op      = ULA_ADD;
        zero_ext    = 1'b0;
        instr_class = CLS_ILLEGAL;
        is_load     = 1'b0;
        is_bne      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                instr_class = CLS_R;
                case (funct)
                    FN_ADD, FN_ADDU: ula_op = ULA_ADD;
                    FN_SUB, FN_SUBU: ula_op = ULA_SUB;
                    FN_AND:          ula_op = ULA_AND;
                    FN_OR:           ula_op = ULA_OR;
                    FN_XOR:          ula_op = ULA_XOR;
                    FN_NOR:          ula_op = ULA_NOR;
                    FN_SLT:          ula_op = ULA_SLT;
                    FN_SLL:          ula_op = ULA_SLL;
                    FN_SRL:          ula_op = ULA_SRL;
                    default:         instr_class = CLS_ILLEGAL;
                endcase
            end
            OP_J:    instr_class = CLS_JUMP;
            OP_BEQ:  begin instr_class = CLS_BRANCH; ula_op = ULA_SUB; end
            OP_BNE:  begin instr_class = CLS_BRANCH; ula_op = ULA_SUB; is_bne = 1'b1; end
            OP_ADDI: begin instr_class = CLS_I; ula_op = ULA_ADD; end
            OP_SLTI: begin instr_class = CLS_I; ula_op = ULA_SLT; end
            OP_ANDI: begin instr_class = CLS_I; ula_op = ULA_AND; zero_ext = 1'b1; end
            OP_ORI:  begin instr_class = CLS_I; ula_op = ULA_OR;  zero_ext = 1'b1; end
            OP_XORI: begin instr_class = CLS_I; ula_op = ULA_XOR; zero_ext = 1'b1; end
            OP_LUI:  begin instr_class = CLS_I; ula_op = ULA_LUI; end
            OP_LW:   begin instr_class = CLS_MEM; is_load = 1'b1; end
            OP_SW:   instr_class = CLS_MEM;
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ula_controle.sv
// rtl/ula_controle.sv - multicycle Moore control sequencer for the 32-bit ULA datapath
module ula_controle
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        Zero_flag,
    output logic [3:0]  ula_op,
    output logic [4:0]  shamt,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        zero_ext,
    output logic        illegal
);

    state_t       state, state_next;
    logic [31:0]  ir;
    logic [3:0]   op_q;
    logic         zext_q, load_q, bne_q;

    logic [3:0]   dec_op;
    logic         dec_zext, dec_load, dec_bne;
    instr_class_t dec_class;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[25:11];

    ula_decoder u_decoder (
        .opcode      (ir[31:26]),
        .funct       (ir[5:0]),
        .ula_op      (dec_op),
        .zero_ext    (dec_zext),
        .instr_class (dec_class),
        .is_load     (dec_load),
        .is_bne      (dec_bne)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir     <= '0;
            op_q   <= ULA_ADD;
            zext_q <= 1'b0;
            load_q <= 1'b0;
            bne_q  <= 1'b0;
        end else begin
            if (state == S_FETCH && mem_ready) ir <= instr;
            if (state == S_DECODE) begin
                op_q   <= dec_op;
                zext_q <= dec_zext;
                load_q <= dec_load;
                bne_q  <= dec_bne;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (dec_class)
                    CLS_R:      state_next = S_EXEC_R;
                    CLS_I:      state_next = S_EXEC_I;
                    CLS_MEM:    state_next = S_ADDR;
                    CLS_BRANCH: state_next = S_BRANCH;
                    CLS_JUMP:   state_next = S_JUMP;
                    default:    state_next = S_FETCH;
                endcase
            end
            S_EXEC_R: state_next = S_WB_R;
            S_EXEC_I: state_next = S_WB_I;
            S_ADDR:   state_next = load_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_next = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore outputs from state and latched op; FETCH handshake and branch decision are the only Mealy terms.
    always_comb begin
        ula_op     = op_q;
        shamt      = ir[10:6];
        pc_write   = 1'b0;
        pc_src     = PCSRC_ULA;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        zero_ext   = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = SRCB_FOUR;
                ula_op    = ULA_ADD;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                ula_op    = ULA_ADD;
                illegal   = (dec_class == CLS_ILLEGAL);
            end
            S_EXEC_R: alu_src_a = 1'b1;
            S_WB_R:   begin reg_write = 1'b1; reg_dst = 1'b1; end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                zero_ext  = zext_q;
            end
            S_WB_I:   reg_write = 1'b1;
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ula_op    = ULA_ADD;
            end
            S_MEM_RD: begin mem_read = 1'b1; iord = 1'b1; end
            S_WB_MEM: begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_MEM_WR: begin mem_write = 1'b1; iord = 1'b1; end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                ula_op    = ULA_SUB;
                pc_src    = PCSRC_BRANCH;
                pc_write  = bne_q ? !Zero_flag : Zero_flag;
            end
            S_JUMP:   begin pc_write = 1'b1; pc_src = PCSRC_JUMP; end
            default:  ;
        endcase
        // Enables must vanish the moment reset asserts, not at the next edge.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            iord      = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
            ula_op    = ULA_ADD;
        end
    end

endmodule

// File: tb/tb_ula_controle.sv
// tb/tb_ula_controle.sv - table-driven self-checking bench for ula_controle
module tb_ula_controle;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero_flag;
    logic [3:0]  ula_op;
    logic [4:0]  shamt;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        zero_ext;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    ula_controle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .Zero_flag  (zero_flag),
        .ula_op     (ula_op),
        .shamt      (shamt),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .zero_ext   (zero_ext),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zf;
        int          fw;
        int          mwt;
        int          cycles;
        logic [3:0]  op;
        logic        chk_op;
        int          rw;
        int          rw_cyc;
        logic        dst;
        logic        m2r;
        int          mw;
        int          ill;
        int          pcw;
        logic [4:0]  sh;
        logic        zx;
        logic [1:0]  psrc;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input vec_t v);
        vt.push_back(v);
    endtask

    // Entered and left at a negedge while the DUT sits in FETCH.
    task automatic run(input int idx, input vec_t v);
        int cyc = 0, rw = 0, rwc = 0, mw = 0, ill = 0, pcw = 0, irw = 0;
        int fw = v.fw, mwt = v.mwt;
        logic d = 0, m = 0, zx = 0;
        logic [3:0] op = 0;
        logic [4:0] sh = 0;
        logic [1:0] ps = 0;
        bit left = 0, done = 0;
        instr     = v.instr;
        zero_flag = v.zf;
        for (int k = 0; k < 40 && !done; k++) begin
            if (left && mem_read && !iord) begin
                done = 1;
            end else begin
                if (!(mem_read && !iord)) left = 1;
                cyc++;
                if (mem_read && !iord && fw > 0) begin
                    mem_ready = 1'b0; fw--;
                end else if (((mem_read && iord) || mem_write) && mwt > 0) begin
                    mem_ready = 1'b0; mwt--;
                end else begin
                    mem_ready = 1'b1;
                end
                #1;
                if (reg_write) begin rw++; rwc = cyc; d = reg_dst; m = mem_to_reg; end
                if (mem_write) mw++;
                if (illegal) ill++;
                if (ir_write) irw++;
                if (pc_write) begin pcw++; ps = pc_src; end
                if (cyc == v.fw + 2) sh = shamt;
                if (cyc == v.fw + 3) begin op = ula_op; zx = zero_ext; end
                @(negedge clk);
            end
        end
        chk($sformatf("v%0d_finished", idx), done, 1);
        chk($sformatf("v%0d_cycles", idx), cyc, v.cycles);
        chk($sformatf("v%0d_reg_write_count", idx), rw, v.rw);
        chk($sformatf("v%0d_reg_write_cycle", idx), rwc, v.rw_cyc);
        chk($sformatf("v%0d_reg_dst", idx), d, v.dst);
        chk($sformatf("v%0d_mem_to_reg", idx), m, v.m2r);
        chk($sformatf("v%0d_mem_write_count", idx), mw, v.mw);
        chk($sformatf("v%0d_illegal_count", idx), ill, v.ill);
        chk($sformatf("v%0d_ir_write_count", idx), irw, 1);
        chk($sformatf("v%0d_pc_write_count", idx), pcw, v.pcw);
        chk($sformatf("v%0d_pc_src", idx), ps, v.psrc);
        chk($sformatf("v%0d_shamt", idx), sh, v.sh);
        chk($sformatf("v%0d_zero_ext", idx), zx, v.zx);
        if (v.chk_op) chk($sformatf("v%0d_ula_op", idx), op, v.op);
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        mem_ready = 1'b0;
        zero_flag = 1'b0;

        //   instr         zf  fw mwt cyc op   chk rw rwc dst m2r mw ill pcw sh     zx  psrc
        add('{32'h00221820, 0, 0, 0, 4, 4'h2, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221821, 0, 0, 0, 4, 4'h2, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221822, 0, 0, 0, 4, 4'h6, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221823, 0, 0, 0, 4, 4'h6, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221824, 0, 0, 0, 4, 4'h0, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221825, 0, 0, 0, 4, 4'h1, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221826, 0, 0, 0, 4, 4'hD, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00221827, 0, 0, 0, 4, 4'hC, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h0022182A, 0, 0, 0, 4, 4'h7, 1, 1, 4, 1, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h00011140, 0, 0, 0, 4, 4'hE, 1, 1, 4, 1, 0, 0, 0, 1, 5'd5,  0, 2'd0});
        add('{32'h00011142, 0, 0, 0, 4, 4'hF, 1, 1, 4, 1, 0, 0, 0, 1, 5'd5,  0, 2'd0});
        add('{32'h20220005, 0, 0, 0, 4, 4'h2, 1, 1, 4, 0, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h3022FFFF, 0, 0, 0, 4, 4'h0, 1, 1, 4, 0, 0, 0, 0, 1, 5'd31, 1, 2'd0});
        add('{32'h34220F0F, 0, 0, 0, 4, 4'h1, 1, 1, 4, 0, 0, 0, 0, 1, 5'd28, 1, 2'd0});
        add('{32'h382200C0, 0, 0, 0, 4, 4'hD, 1, 1, 4, 0, 0, 0, 0, 1, 5'd3,  1, 2'd0});
        add('{32'h2822FFFF, 0, 0, 0, 4, 4'h7, 1, 1, 4, 0, 0, 0, 0, 1, 5'd31, 0, 2'd0});
        add('{32'h3C011234, 0, 0, 0, 4, 4'hB, 1, 1, 4, 0, 0, 0, 0, 1, 5'd8,  0, 2'd0});
        add('{32'h8C220004, 0, 0, 0, 5, 4'h2, 1, 1, 5, 0, 1, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h8C220004, 0, 2, 1, 8, 4'h2, 1, 1, 8, 0, 1, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'hAC220004, 0, 0, 0, 4, 4'h2, 1, 0, 0, 0, 0, 1, 0, 1, 5'd0,  0, 2'd0});
        add('{32'hAC220004, 0, 1, 2, 7, 4'h2, 1, 0, 0, 0, 0, 3, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h10220003, 1, 0, 0, 3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 2, 5'd0,  0, 2'd1});
        add('{32'h10220003, 0, 0, 0, 3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h14220003, 1, 0, 0, 3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0,  0, 2'd0});
        add('{32'h14220003, 0, 0, 0, 3, 4'h6, 1, 0, 0, 0, 0, 0, 0, 2, 5'd0,  0, 2'd1});
        add('{32'h08000010, 0, 0, 0, 3, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2, 5'd0,  0, 2'd2});
        add('{32'hFC000000, 0, 0, 0, 2, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd0,  0, 2'd0});
        add('{32'h00221801, 0, 0, 0, 2, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd0,  0, 2'd0});
        add('{32'hFC0007C0, 0, 1, 0, 3, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd31, 0, 2'd0});

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ula_op", ula_op, 4'b0010);
        chk("rst_shamt", shamt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_mem_read", mem_read, 1);
        chk("post_rst_iord", iord, 0);
        chk("post_rst_alu_src_b", alu_src_b, 2'd1);
        @(negedge clk);

        foreach (vt[i]) run(i, vt[i]);

        // Reset asserted while a store is waiting on memory
        begin
            bit seen = 0;
            instr     = 32'hAC2207C4;
            zero_flag = 1'b0;
            mem_ready = 1'b1;
            for (int k = 0; k < 10 && !seen; k++) begin
                #1;
                if (mem_write) seen = 1;
                else @(negedge clk);
            end
            chk("midwr_reached_mem_wr", seen, 1);
            mem_ready = 1'b0;
            @(negedge clk);
            #1;
            chk("midwr_waiting_mem_write", mem_write, 1);
            chk("midwr_waiting_shamt", shamt, 5'd31);
            #1;
            rst_n = 1'b0;
            #1;
            chk("midwr_rst_mem_write", mem_write, 0);
            chk("midwr_rst_mem_read", mem_read, 0);
            chk("midwr_rst_reg_write", reg_write, 0);
            chk("midwr_rst_ula_op", ula_op, 4'b0010);
            chk("midwr_rst_shamt", shamt, 0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("midwr_post_mem_read", mem_read, 1);
            chk("midwr_post_iord", iord, 0);
            chk("midwr_post_mem_write", mem_write, 0);
            chk("midwr_post_ula_op", ula_op, 4'b0010);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ula_controle.md
# ula_controle

Multicycle control sequencer that drives the 32-bit ULA (ALU) datapath. It fetches an instruction over a ready-handshaked memory port, decodes the MIPS opcode and funct fields, and issues the 4-bit ULA operation codes. It sequences the register-file, memory and PC enables through a Moore state machine. It sits between instruction/data memory and the datapath that contains the ULA, and consumes the ULA `Zero_flag` for branches.

## Interface
- No parameters. Widths are fixed by the 32-bit MIPS datapath.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `instr` in 32 — memory read data; captured into the internal IR on the FETCH→DECODE transition.
- `mem_ready` in 1 — memory completes the current read or write this cycle.
- `Zero_flag` in 1 — ULA zero result, sampled in BRANCH.
- `ula_op` out 4 — ULA operation code.
- `shamt` out 5 — IR[10:6], held while the IR is valid.
- `pc_write` out 1 — load PC.
- `pc_src` out 2 — next-PC source: 0 = ULA result (PC+4), 1 = branch target, 2 = jump target.
- `ir_write` out 1 — load IR in the datapath.
- `mem_read` out 1 — memory read request.
- `mem_write` out 1 — memory write request.
- `iord` out 1 — memory address source: 0 = PC, 1 = ULA output register.
- `reg_write` out 1 — register-file write enable.
- `reg_dst` out 1 — write-register select: 0 = rt, 1 = rd.
- `mem_to_reg` out 1 — write-back source: 0 = ULA, 1 = MDR.
- `alu_src_a` out 1 — ULA In1 source: 0 = PC, 1 = rs.
- `alu_src_b` out 2 — ULA In2 source: 0 = rt, 1 = constant 4, 2 = extended imm, 3 = extended imm << 2.
- `zero_ext` out 1 — 1 selects zero-extension of imm (andi/ori/xori); otherwise sign-extension.
- `illegal` out 1 — one-cycle pulse on an unknown opcode or funct.

## Operation
- ULA codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, LUI 1011, NOR 1100, XOR 1101, SLL 1110, SRL 1111.
- Funct mapping (R-type):
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB
  - 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR
  - 0x2A → SLT; 0x00 → SLL; 0x02 → SRL
- Opcode mapping:
  - 0x00 → R-type
  - 0x02 → j; 0x04 → beq; 0x05 → bne (both use SUB)
  - 0x08 → addi (ADD); 0x0A → slti (SLT)
  - 0x0C → andi (AND); 0x0D → ori (OR); 0x0E → xori (XOR)
  - 0x0F → lui (LUI)
  - 0x23 → lw; 0x2B → sw (both use ADD)
- States and transitions:
  - FETCH: mem_read=1, iord=0.
    - On mem_ready: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=1, ula_op=ADD; go to DECODE.
    - Otherwise hold.
  - DECODE: alu_src_a=0, alu_src_b=3, ula_op=ADD (branch target precompute). Latch the decoded op. Next state:
    - R-type → EXEC_R
    - immediate ALU ops → EXEC_I
    - lw/sw → ADDR
    - beq/bne → BRANCH
    - j → JUMP
    - unknown → FETCH, with illegal=1 for one cycle
  - EXEC_R: alu_src_a=1, alu_src_b=0 → WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=2, zero_ext per opcode → WB_I.
  - WB_I: reg_write=1, reg_dst=0 → FETCH.
  - ADDR: alu_src_a=1, alu_src_b=2, ADD → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: mem_read=1, iord=1; hold until mem_ready → WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
  - MEM_WR: mem_write=1, iord=1; hold until mem_ready → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_write = Zero_flag for beq, !Zero_flag for bne → FETCH.
  - JUMP: pc_write=1, pc_src=2 → FETCH.
- An unknown funct under opcode 0x00 is treated as illegal in DECODE; no register write occurs.

## Timing
- Outputs are a Moore decode of the state plus the latched op; no output depends combinationally on `instr` or `mem_ready`, except `ir_write`/`pc_write` in FETCH and the branch `pc_write`.
- Cycle counts with zero wait states: R-type 4, immediate 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2. Each memory wait cycle adds 1.
- Reset: state=FETCH, IR=0, latched op=ADD. All enables and `illegal` are 0 while rst_n=0; `ula_op`=0010, `shamt`=0.
- Reset asserted mid-instruction aborts it at once. No partial register or memory write survives; `mem_write` drops asynchronously.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.

## Structure
- Package `ula_pkg` holds:
  - the ULA op localparams (ULA_AND … ULA_SRL)
  - opcode and funct constants
  - the state encoding
  - the `alu_src_b`/`pc_src` select encodings
- Sub-module `ula_decoder`: combinational map of opcode/funct to ula_op, zero_ext, instruction class and illegal. It is instantiated once in the top.

## Test plan
- Reset mid-MEM_WR (rst_n low) → mem_write=0 immediately; after release: state FETCH, mem_read=1, ula_op=0010.
- `add $3,$1,$2` (0x00221820), mem_ready always 1 → ula_op=0010 in EXEC_R; reg_write=1 with reg_dst=1 exactly on cycle 4; return to FETCH on cycle 5.
- `lw` (0x8C220004) with 2 wait cycles in FETCH and 1 in MEM_RD → 8 cycles total; reg_write=1 with mem_to_reg=1 once.
- `beq` with Zero_flag=1 → pc_write=1, pc_src=1 in BRANCH. `bne` with Zero_flag=1 → pc_write=0.
- `sll $2,$1,5` (0x00011140) → ula_op=1110, shamt=5. `andi` (0x3022FFFF) → zero_ext=1, ula_op=0000.
- Opcode 0x3F → illegal pulses for exactly 1 cycle; no reg_write or mem_write; next state FETCH.
